// File: rtl/range_result_fifo.sv
// range_result_fifo: snoops the range finder's go/finish controls and its
// range/error outputs, queues each error-free result in a small first-word
// fall-through FIFO, counts errored sequences and flags dropped results.
module range_result_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    parameter  int ERRW  = 8,
    localparam int PTRW  = $clog2(DEPTH),
    localparam int FILLW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             finish,
    input  logic [WIDTH-1:0] range,
    input  logic             error,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [FILLW-1:0] fill,
    output logic [ERRW-1:0]  err_count,
    output logic             overflow
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;

    logic pop;
    logic full;
    logic push_req;
    logic push;
    logic drop;
    logic err_inc;

    // A result is offered one cycle after finish, once the finisher has
    // registered range/error. At full, a simultaneous pop frees the slot.
    assign data_valid = (fill != '0);
    assign pop        = data_valid && data_ready;
    assign full       = (fill == FILLW'(DEPTH));
    assign push_req   = (state == PENDING) && !error;
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign err_inc    = ((state == IDLE) && finish && go) ||
                        ((state == PENDING) && error);

    // Head of queue falls through; an empty FIFO presents zero rather than
    // stale memory contents.
    assign data_out = data_valid ? mem[rd_ptr] : '0;

    // Capture FSM, FIFO pointers/occupancy, error counter and sticky overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (finish && !go) state <= PENDING;
                PENDING: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);

            case ({push, pop})
                2'b10:   fill <= fill + FILLW'(1);
                2'b01:   fill <= fill - FILLW'(1);
                default: fill <= fill;
            endcase

            if (err_inc && (err_count != '1)) err_count <= err_count + ERRW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage array written at the write pointer on an accepted push.
    // NOTE: the memory has no reset; occupancy and pointers are reset, and
    // data_out is masked while empty, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= range;
    end

endmodule

// File: doc/range_result_fifo.md
Name: range_result_fifo

Overview:
- Downstream consumer of the range-finder stage.
- Snoops the same go/finish controls that drive the range finder, plus its range and error outputs.
- Captures each completed, error-free range result into a small FIFO and presents it on a valid/ready interface to the reporting logic.
- Counts protocol-error sequences and flags dropped results.

Parameters:
WIDTH, 16, width of range / data_out (matches range finder WIDTH)
DEPTH, 4, FIFO entries; power of two, >= 2
ERRW, 8, width of saturating error counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets all state)
go  input  1  same go signal driven to range finder
finish  input  1  same finish signal driven to range finder
range  input  WIDTH  range finder result
error  input  1  range finder error output
clear  input  1  synchronous flush: empties FIFO, zeroes counters and flags
data_out  output  WIDTH  head-of-FIFO range value
data_valid  output  1  data_out holds a valid entry (FIFO not empty)
data_ready  input  1  consumer accepts data_out when data_valid&&data_ready
fill  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH
err_count  output  ERRW  saturating count of errored sequences
overflow  output  1  sticky: a good result was dropped because FIFO full

Behaviour:
- Reset (reset==0, asynchronous): FIFO empty, fill=0, data_valid=0, data_out=0, err_count=0, overflow=0, capture FSM in IDLE. Takes effect immediately, mid-operation included. Any pending capture is lost.
- Capture FSM, two states:
  - IDLE: at posedge with finish=1, go=0 -> PENDING.
  - IDLE: at posedge with finish=1, go=1 (illegal simultaneous) -> err_count+1, stay IDLE.
  - PENDING: range/error are now the finisher's registered result. At next posedge:
    - error==0 -> push range;
    - error==1 -> err_count+1.
    - Always return to IDLE.
  - PENDING: a new finish in the PENDING cycle is ignored (not queued).
- Capture latency: finish sampled at edge N -> entry visible (data_valid/fill updated) after edge N+1.
- err_count saturates at 2^ERRW-1; never wraps.
- FIFO:
  - Circular buffer, read/write pointers, first-word fall-through: data_out = mem[rd_ptr] whenever data_valid=1.
  - data_out = 0 when empty.
  - Pop when data_valid&&data_ready; data_ready ignored when empty.
  - Push and pop in the same cycle: both occur, fill unchanged. Allowed even when full, since the pop frees the slot first.
  - Push when full and no pop: value dropped, overflow<=1, FIFO contents unchanged.
  - Pointers wrap modulo DEPTH; fill tracked separately. Full is fill==DEPTH.
- clear (synchronous, when reset==1): same end state as reset at next posedge. Overrides a simultaneous push/pop/err increment and cancels PENDING.
- All outputs registered except data_out (mem read at rd_ptr) and data_valid (fill!=0).

Test Plan:
- Single result: go, then data 7FFF,8000,8001,7FFE, finish; range=0003, error=0 at PENDING edge -> fill=1, data_valid=1, data_out=0003 two edges after finish sampled. Pulse data_ready -> fill=0, data_valid=0.
- Errors:
  - go&finish together -> err_count=1, fill=0.
  - finish without go (range finder raises error) -> err_count=2, no push.
  - Set err_count near 2^ERRW-1 via repeated errors -> holds at FF.
- Fill and overflow (DEPTH=4): push ranges 0001,0002,0003,0004 with data_ready=0 -> fill=4. A fifth result 0005 -> dropped, overflow=1, fill=4. Pops then return 0001..0004 in order; overflow stays 1.
- Simultaneous push/pop at full: full FIFO, data_ready=1 on the push edge of 0006 -> fill stays 4, no overflow. Next heads are 0002,0003,0004,0006.
- Pointer wrap: 10 push/pop pairs with DEPTH=4 -> data order preserved, fill returns to 0.
- clear / reset:
  - clear asserted while PENDING with a valid result -> no push, fill=0, err_count=0, overflow=0.
  - reset=0 mid-stream (fill=3) -> immediate fill=0, data_valid=0, data_out=0, without waiting for a clock edge.
